// File: rtl/wb_rr_arbiter_if.sv
// Wishbone B4 classic link between one bus master and one bus slave.
//   master modport : drives adr/wdat/sel/we/cyc/stb/cti/bte, receives rdat/ack/err/rty
//   slave modport  : the mirror image
interface wb_rr_arbiter_if;
   logic [31:0] adr;
   logic [31:0] wdat;   // master -> slave write data
   logic [31:0] rdat;   // slave -> master read data
   logic [3:0]  sel;
   logic        we;
   logic        cyc;
   logic        stb;
   logic [2:0]  cti;
   logic [1:0]  bte;
   logic        ack;
   logic        err;
   logic        rty;

   modport master (
      output adr, wdat, sel, we, cyc, stb, cti, bte,
      input  rdat, ack, err, rty
   );

   modport slave (
      input  adr, wdat, sel, we, cyc, stb, cti, bte,
      output rdat, ack, err, rty
   );
endinterface

// File: rtl/wb_rr_arbiter.sv
// Two-master round-robin Wishbone B4 classic arbiter with per-access watchdog.
// The bus is granted for a whole cyc tenure; a strobed access that sees no
// ack/err/rty within TIMEOUT cycles is terminated towards its master with err.
//
// Ports:
//   wb_clk_i   clock, all state on rising edge
//   wb_rst_i   synchronous active-high reset
//   m0_io      master 0 (core wishbone_controller), slave side of its link
//   m1_io      master 1 (boot/flash copy engine), slave side of its link
//   s_io       shared link towards wb_intercon, master side
//   grant_o    one-hot current owner, 2'b00 when idle
//   timeout_o  one-cycle pulse when the watchdog aborts an access
//
// state    | meaning
// ---------+----------------------------------------------------------
// ST_IDLE  | bus released, arbitrating between pending cyc requests
// ST_OWN   | owner_q holds the bus, s_* mirror the owner's inputs
// ST_ABORT | watchdog expired: bus dropped, err returned to the owner
module wb_rr_arbiter #(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic                   wb_clk_i,
   input  logic                   wb_rst_i,
   wb_rr_arbiter_if.slave         m0_io,
   wb_rr_arbiter_if.slave         m1_io,
   wb_rr_arbiter_if.master        s_io,
   output logic [1:0]             grant_o,
   output logic                   timeout_o
);

   localparam int unsigned       CW     = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CW-1:0]     CNT_TC = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_OWN   = 2'd1,
      ST_ABORT = 2'd2
   } state_t;

   state_t        state_q;
   logic          owner_q;
   logic          last_q;
   logic [1:0]    grant_q;
   logic          timeout_q;
   logic [CW-1:0] cnt_q;

   logic own;
   logic abort;
   logic owner_cyc;
   logic term;
   logic wd_fire;
   logic pick;

   assign own       = (state_q == ST_OWN);
   assign abort     = (state_q == ST_ABORT);
   assign owner_cyc = owner_q ? m1_io.cyc : m0_io.cyc;
   assign term      = s_io.ack | s_io.err | s_io.rty;
   // A termination in the terminal-count cycle wins over the abort.
   assign wd_fire   = (TIMEOUT > 0) && s_io.stb && !term && (cnt_q == CNT_TC);
   // On contention the master not served last wins.
   assign pick      = (m0_io.cyc && m1_io.cyc) ? ~last_q : m1_io.cyc;

   assign s_io.adr  = own ? (owner_q ? m1_io.adr  : m0_io.adr)  : '0;
   assign s_io.wdat = own ? (owner_q ? m1_io.wdat : m0_io.wdat) : '0;
   assign s_io.sel  = own ? (owner_q ? m1_io.sel  : m0_io.sel)  : '0;
   assign s_io.we   = own & (owner_q ? m1_io.we  : m0_io.we);
   assign s_io.cyc  = own & owner_cyc;
   assign s_io.stb  = own & (owner_q ? m1_io.stb : m0_io.stb);
   assign s_io.cti  = own ? (owner_q ? m1_io.cti  : m0_io.cti)  : '0;
   assign s_io.bte  = own ? (owner_q ? m1_io.bte  : m0_io.bte)  : '0;

   assign m0_io.rdat = s_io.rdat;
   assign m1_io.rdat = s_io.rdat;

   // Slave terminations reach the owner only; a late ack during abort is dropped.
   assign m0_io.ack = own & ~owner_q & s_io.ack;
   assign m0_io.rty = own & ~owner_q & s_io.rty;
   assign m0_io.err = ~owner_q & ((own & s_io.err) | abort);
   assign m1_io.ack = own &  owner_q & s_io.ack;
   assign m1_io.rty = own &  owner_q & s_io.rty;
   assign m1_io.err =  owner_q & ((own & s_io.err) | abort);

   assign grant_o   = grant_q;
   assign timeout_o = timeout_q;

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state_q   <= ST_IDLE;
         owner_q   <= 1'b0;
         last_q    <= 1'b1;
         grant_q   <= 2'b00;
         timeout_q <= 1'b0;
         cnt_q     <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               cnt_q <= '0;
               if (m0_io.cyc || m1_io.cyc) begin
                  state_q <= ST_OWN;
                  owner_q <= pick;
                  grant_q <= pick ? 2'b10 : 2'b01;
               end
            end
            ST_OWN: begin
               if (!owner_cyc) begin
                  state_q <= ST_IDLE;
                  last_q  <= owner_q;
                  grant_q <= 2'b00;
                  cnt_q   <= '0;
               end else if (wd_fire) begin
                  state_q   <= ST_ABORT;
                  timeout_q <= 1'b1;
                  cnt_q     <= '0;
               end else if (term || !s_io.stb || TIMEOUT == 0) begin
                  cnt_q <= '0;
               end else begin
                  cnt_q <= cnt_q + CW'(1);
               end
            end
            ST_ABORT: begin
               state_q   <= ST_IDLE;
               last_q    <= owner_q;
               grant_q   <= 2'b00;
               timeout_q <= 1'b0;
               cnt_q     <= '0;
            end
            default: begin
               state_q   <= ST_IDLE;
               grant_q   <= 2'b00;
               timeout_q <= 1'b0;
               cnt_q     <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Directed bench for wb_rr_arbiter. Instance dut_a runs with TIMEOUT=4,
// dut_b with TIMEOUT=0. The bench acts as both masters and as the slave.
module tb_wb_rr_arbiter;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   wb_rr_arbiter_if m0a ();
   wb_rr_arbiter_if m1a ();
   wb_rr_arbiter_if sla ();
   wb_rr_arbiter_if m0b ();
   wb_rr_arbiter_if m1b ();
   wb_rr_arbiter_if slb ();

   logic [1:0] ga, gb;
   logic       toa, tob;

   wb_rr_arbiter #(.TIMEOUT(4)) dut_a (
      .wb_clk_i(clk), .wb_rst_i(rst),
      .m0_io(m0a), .m1_io(m1a), .s_io(sla),
      .grant_o(ga), .timeout_o(toa)
   );

   wb_rr_arbiter #(.TIMEOUT(0)) dut_b (
      .wb_clk_i(clk), .wb_rst_i(rst),
      .m0_io(m0b), .m1_io(m1b), .s_io(slb),
      .grant_o(gb), .timeout_o(tob)
   );

   int          n_cmp = 0;
   int          n_bad = 0;
   logic [31:0] exp_q[$];
   logic        m1_ack_seen;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic pop_chk(input string tag, input logic [31:0] obs);
      logic [31:0] e;
      if (exp_q.size() == 0) begin
         n_cmp++;
         n_bad++;
         $error("FAIL %s: observed %h expected <scoreboard empty>", tag, obs);
      end else begin
         e = exp_q.pop_front();
         chk(tag, obs, e);
      end
   endtask

   // Drive point: just after the rising edge.
   task automatic nxt();
      @(posedge clk);
      #1;
   endtask

   // Sample point: falling edge, mid-cycle.
   task automatic smp();
      @(negedge clk);
      m1_ack_seen = m1_ack_seen | m1a.ack;
   endtask

   task automatic clr_master(input int unsigned which);
      case (which)
         0: begin m0a.cyc = 0; m0a.stb = 0; m0a.we = 0; m0a.adr = '0; m0a.wdat = '0; m0a.sel = '0; m0a.cti = '0; m0a.bte = '0; end
         1: begin m1a.cyc = 0; m1a.stb = 0; m1a.we = 0; m1a.adr = '0; m1a.wdat = '0; m1a.sel = '0; m1a.cti = '0; m1a.bte = '0; end
         2: begin m0b.cyc = 0; m0b.stb = 0; m0b.we = 0; m0b.adr = '0; m0b.wdat = '0; m0b.sel = '0; m0b.cti = '0; m0b.bte = '0; end
         default: begin m1b.cyc = 0; m1b.stb = 0; m1b.we = 0; m1b.adr = '0; m1b.wdat = '0; m1b.sel = '0; m1b.cti = '0; m1b.bte = '0; end
      endcase
   endtask

   initial begin
      int n0, n1, w0, w1, max0, max1, bad;
      logic drop0, drop1;

      for (int i = 0; i < 4; i++) clr_master(i);
      sla.ack = 0; sla.err = 0; sla.rty = 0; sla.rdat = '0;
      slb.ack = 0; slb.err = 0; slb.rty = 0; slb.rdat = '0;
      m1_ack_seen = 1'b0;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      // ---------------- reset values
      smp();
      chk("rst_grant_a", {30'd0, ga}, 0);
      chk("rst_grant_b", {30'd0, gb}, 0);
      chk("rst_timeout", {31'd0, toa}, 0);
      chk("rst_s_ctl", {29'd0, sla.cyc, sla.stb, sla.we}, 0);
      chk("rst_s_adr", sla.adr, 0);
      chk("rst_s_bus", {sla.wdat[22:0], sla.sel, sla.cti, sla.bte}, 0);
      chk("rst_m_term", {26'd0, m0a.ack, m0a.err, m0a.rty, m1a.ack, m1a.err, m1a.rty}, 0);

      // ---------------- single master read
      m1_ack_seen = 1'b0;
      nxt();
      m0a.cyc = 1; m0a.stb = 1; m0a.we = 0; m0a.adr = 32'h0000_0010;
      m0a.sel = 4'hF; m0a.cti = 3'b010; m0a.bte = 2'b01;
      exp_q.push_back(32'h1);
      smp();
      chk("t1_grant_lat", {30'd0, ga}, 0);
      chk("t1_scyc_lat", {31'd0, sla.cyc}, 0);
      nxt(); smp();
      pop_chk("t1_grant", {30'd0, ga});
      chk("t1_s_adr", sla.adr, 32'h0000_0010);
      chk("t1_s_ctl", {20'd0, sla.cyc, sla.stb, sla.we, sla.sel, sla.cti, sla.bte}, {20'd0, 3'b110, 4'hF, 3'b010, 2'b01});
      nxt(); smp();
      chk("t1_no_early_ack", {31'd0, m0a.ack}, 0);
      nxt();
      sla.ack = 1; sla.rdat = 32'hDEAD_BEEF;
      exp_q.push_back(32'hDEAD_BEEF);
      smp();
      chk("t1_ack", {31'd0, m0a.ack}, 1);
      pop_chk("t1_rdat", m0a.rdat);
      chk("t1_m1_rdat", m1a.rdat, 32'hDEAD_BEEF);
      nxt();
      sla.ack = 0; clr_master(0);
      smp();
      chk("t1_release_scyc", {31'd0, sla.cyc}, 0);
      nxt(); smp();
      chk("t1_idle_grant", {30'd0, ga}, 0);
      chk("t1_m1_ack_never", {31'd0, m1_ack_seen}, 0);

      // ---------------- reset mid-access (last is 0 here from the m0 tenure)
      nxt();
      m0a.cyc = 1; m0a.stb = 1; m0a.we = 1; m0a.adr = 32'h20; m0a.wdat = 32'h55; m0a.sel = 4'hF;
      exp_q.push_back(32'h1);
      nxt(); smp();
      pop_chk("rm_grant", {30'd0, ga});
      chk("rm_scyc", {31'd0, sla.cyc}, 1);
      nxt();
      rst = 1;
      smp();
      nxt();
      rst = 0; clr_master(0);
      smp();
      chk("rm_grant_after", {30'd0, ga}, 0);
      chk("rm_scyc_after", {31'd0, sla.cyc}, 0);
      chk("rm_no_term", {29'd0, m0a.ack, m0a.err, toa}, 0);

      // ---------------- simultaneous requests (last restored to 1 by reset)
      nxt();
      m0a.cyc = 1; m0a.stb = 1; m0a.we = 1; m0a.adr = 32'h100; m0a.wdat = 32'h1111_1111; m0a.sel = 4'hF;
      m1a.cyc = 1; m1a.stb = 1; m1a.we = 1; m1a.adr = 32'h200; m1a.wdat = 32'h2222_2222; m1a.sel = 4'hF;
      exp_q.push_back(32'h1);
      exp_q.push_back(32'h2);
      smp();
      chk("t2_grant_lat", {30'd0, ga}, 0);
      nxt();
      sla.ack = 1;
      smp();
      pop_chk("t2_grant_first", {30'd0, ga});
      chk("t2_s_adr0", sla.adr, 32'h100);
      chk("t2_s_dat0", sla.wdat, 32'h1111_1111);
      chk("t2_acks0", {30'd0, m0a.ack, m1a.ack}, 2);
      nxt();
      sla.ack = 0; clr_master(0);
      smp();
      nxt(); smp();
      chk("t2_gap", {30'd0, ga}, 0);
      nxt();
      sla.ack = 1;
      smp();
      pop_chk("t2_grant_second", {30'd0, ga});
      chk("t2_s_adr1", sla.adr, 32'h200);
      chk("t2_s_dat1", sla.wdat, 32'h2222_2222);
      chk("t2_acks1", {30'd0, m0a.ack, m1a.ack}, 1);
      nxt();
      sla.ack = 0; clr_master(1);
      smp();
      nxt();
      m0a.cyc = 1; m0a.stb = 1; m1a.cyc = 1; m1a.stb = 1;
      exp_q.push_back(32'h1);
      nxt(); smp();
      pop_chk("t2_round2", {30'd0, ga});
      nxt();
      clr_master(0); clr_master(1);
      repeat (3) nxt();

      // ---------------- fairness under continuous load
      rst = 1;
      nxt();
      rst = 0;
      for (int i = 0; i < 8; i++) begin
         exp_q.push_back(32'h1);
         exp_q.push_back(32'h2);
      end
      sla.ack = 1;
      n0 = 0; n1 = 0; w0 = 0; w1 = 0; max0 = 0; max1 = 0;
      drop0 = 0; drop1 = 0;
      for (int c = 0; c < 200 && (n0 < 8 || n1 < 8); c++) begin
         m0a.cyc = (n0 < 8) && !drop0; m0a.stb = m0a.cyc;
         m1a.cyc = (n1 < 8) && !drop1; m1a.stb = m1a.cyc;
         drop0 = 0; drop1 = 0;
         smp();
         if (ga != 2'b00 && sla.stb) begin
            pop_chk("fair_order", {30'd0, ga});
            if (ga[1]) begin n1++; drop1 = 1; end
            else       begin n0++; drop0 = 1; end
         end
         w0 = (m0a.cyc && ga != 2'b01) ? w0 + 1 : 0;
         w1 = (m1a.cyc && ga != 2'b10) ? w1 + 1 : 0;
         if (w0 > max0) max0 = w0;
         if (w1 > max1) max1 = w1;
         nxt();
      end
      chk("fair_m0_count", n0, 8);
      chk("fair_m1_count", n1, 8);
      // Worst wait: request cycle in IDLE + other tenure (ack + release) + IDLE.
      chk("fair_m0_wait", {31'd0, max0 <= 4}, 1);
      chk("fair_m1_wait", {31'd0, max1 <= 4}, 1);
      sla.ack = 0; clr_master(0); clr_master(1);
      repeat (3) nxt();

      // ---------------- watchdog abort, TIMEOUT=4
      m1a.cyc = 1; m1a.stb = 1; m1a.adr = 32'hBAD0_0000;
      exp_q.push_back(32'h2);
      nxt(); smp();
      pop_chk("wd_grant", {30'd0, ga});
      chk("wd_no_err_c0", {30'd0, m1a.err, toa}, 0);
      for (int k = 0; k < 3; k++) begin
         nxt(); smp();
         chk("wd_no_err_early", {30'd0, m1a.err, toa}, 0);
      end
      nxt();
      sla.ack = 1;
      smp();
      chk("wd_err", {31'd0, m1a.err}, 1);
      chk("wd_timeout", {31'd0, toa}, 1);
      chk("wd_scyc", {30'd0, sla.cyc, sla.stb}, 0);
      chk("wd_late_ack", {30'd0, m1a.ack, m0a.err}, 0);
      nxt();
      sla.ack = 0; clr_master(1);
      smp();
      chk("wd_after", {28'd0, ga, toa, m1a.err}, 0);
      nxt();

      // ---------------- ack in the terminal-count cycle beats the abort
      m1a.cyc = 1; m1a.stb = 1; m1a.adr = 32'hBAD0_0000;
      exp_q.push_back(32'h2);
      nxt(); smp();
      pop_chk("wd2_grant", {30'd0, ga});
      nxt(); nxt();
      nxt();
      sla.ack = 1; sla.rdat = 32'h1234_5678;
      smp();
      chk("wd2_ack", {31'd0, m1a.ack}, 1);
      chk("wd2_no_err", {30'd0, m1a.err, toa}, 0);
      nxt();
      sla.ack = 0; clr_master(1);
      smp();
      chk("wd2_no_abort", {30'd0, m1a.err, toa}, 0);
      chk("wd2_grant_hold", {30'd0, ga}, 2);
      nxt();

      // ---------------- watchdog disabled, TIMEOUT=0
      m0b.cyc = 1; m0b.stb = 1; m0b.adr = 32'hBAD0_0004;
      exp_q.push_back(32'h1);
      nxt(); smp();
      pop_chk("t0_grant", {30'd0, gb});
      bad = 0;
      for (int k = 0; k < 1000; k++) begin
         nxt(); smp();
         if (m0b.err || tob || gb !== 2'b01 || m0b.ack) bad++;
      end
      chk("t0_hold", bad, 0);
      nxt();
      slb.ack = 1; slb.rdat = 32'hCAFE_F00D;
      exp_q.push_back(32'hCAFE_F00D);
      smp();
      chk("t0_ack", {30'd0, m0b.ack, m0b.err}, 2);
      pop_chk("t0_rdat", m0b.rdat);
      nxt();
      slb.ack = 0; clr_master(2);
      nxt();

      chk("sb_drained", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
